reg_file: RTL and testbench

//  CPU register file feeding the ALU operand inputs (r0, rX) and capturing the writeback (ALU result,

---
 rtl/reg_file.sv | 135 +++++++++++++
 tb/tb_reg_file.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// CPU register file with an r0 save-stack and a registered zero flag.
// Optional build macro REG_FILE_BYPASS_EN: when defined, the read ports show the next-state value
// (write-first forwarding, including pop into r0). When undefined, the read ports show the current
// registered values.
module reg_file #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_REGS)-1:0] rx_index,
  output logic [DATA_WIDTH-1:0]       r0,
  output logic [DATA_WIDTH-1:0]       rX,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_index,
  input  logic [1:0]                  wr_src,
  input  logic [DATA_WIDTH-1:0]       alu_result,
  input  logic [DATA_WIDTH-1:0]       immediate,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        err_clr,
  output logic                        stack_full,
  output logic                        stack_empty,
  output logic                        stack_err,
  output logic                        flag_zero
);

  localparam int unsigned SW = $clog2(STACK_DEPTH);
  localparam int unsigned CW = SW + 1;

  logic [DATA_WIDTH-1:0] regs_q  [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d  [NUM_REGS];
  logic [DATA_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic                  err_q, err_d;
  logic                  zero_q, zero_d;

  logic                  full, empty;
  logic                  push_ok, pop_ok, err_set;
  logic [SW-1:0]         top_idx;
  logic [DATA_WIDTH-1:0] top_data;
  logic [DATA_WIDTH-1:0] rx_old;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_applied;

  assign full     = (count_q == CW'(STACK_DEPTH));
  assign empty    = (count_q == '0);
  // Wraps correctly when count equals STACK_DEPTH; unused when empty.
  assign top_idx  = count_q[SW-1:0] - SW'(1);
  assign top_data = stack_q[top_idx];
  // Un-forwarded rX, so wr_src=3 never forms a combinational loop through the bypass.
  assign rx_old   = regs_q[rx_index];

  assign push_ok  = push & ~pop & ~full;
  assign pop_ok   = pop & ~push & ~empty;
  assign err_set  = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
  // A valid pop owns r0 for this cycle; writes to other indices still go through.
  assign wr_applied = wr_en & ~(pop_ok & (wr_index == '0));

  // Writeback source select.
  always_comb begin
    wr_data = alu_result;
    unique case (wr_src)
      2'd0: wr_data = alu_result;
      2'd1: wr_data = immediate;
      2'd2: wr_data = mem_rdata;
      2'd3: wr_data = rx_old;
    endcase
  end

  // Next state for registers, stack count and flags.
  always_comb begin
    regs_d  = regs_q;
    count_d = count_q;
    zero_d  = zero_q;
    if (wr_applied) begin
      regs_d[wr_index] = wr_data;
    end
    if (pop_ok) begin
      regs_d[0] = top_data;
    end
    if (push_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok) begin
      count_d = count_q - CW'(1);
    end
    // When a pop and a write to another index coincide, the popped value sets the flag.
    if (pop_ok) begin
      zero_d = (top_data == '0);
    end else if (wr_en) begin
      zero_d = (wr_data == '0);
    end
    err_d = err_set | (err_q & ~err_clr);
  end

  // Architectural state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  // Stack storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_q[count_q[SW-1:0]] <= regs_q[0];
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign r0 = regs_d[0];
  assign rX = regs_d[rx_index];
`else
  assign r0 = regs_q[0];
  assign rX = regs_q[rx_index];
`endif

  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;
  assign flag_zero   = zero_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random stimulus against a
// queue-based reference model.
module tb_reg_file;

  localparam int NR = 8;
  localparam int DW = 8;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    rx_index;
  logic [DW-1:0] r0, rX;
  logic          wr_en;
  logic [2:0]    wr_index;
  logic [1:0]    wr_src;
  logic [DW-1:0] alu_result, immediate, mem_rdata;
  logic          push, pop, err_clr;
  logic          stack_full, stack_empty, stack_err, flag_zero;

  reg_file #(
    .NUM_REGS    (NR),
    .DATA_WIDTH  (DW),
    .STACK_DEPTH (SD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_index    (rx_index),
    .r0          (r0),
    .rX          (rX),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .wr_src      (wr_src),
    .alu_result  (alu_result),
    .immediate   (immediate),
    .mem_rdata   (mem_rdata),
    .push        (push),
    .pop         (pop),
    .err_clr     (err_clr),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err),
    .flag_zero   (flag_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: current and predicted-next state.
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] n_regs [NR];
  logic [DW-1:0] m_stk [$];
  logic [DW-1:0] n_stk [$];
  logic          m_err, n_err, m_zero, n_zero;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_stk.delete();
    m_err  = 1'b0;
    m_zero = 1'b1;
  endtask

  task automatic set_idle();
    wr_en = 0; wr_index = 0; wr_src = 0;
    alu_result = 0; immediate = 0; mem_rdata = 0;
    push = 0; pop = 0; err_clr = 0;
  endtask

  // Apply the architectural rules to the current inputs to predict next state.
  task automatic predict();
    logic [DW-1:0] wdata;
    logic [DW-1:0] pv;
    bit            pop_ok, push_ok, was_full, was_empty;
    n_regs    = m_regs;
    n_stk     = m_stk;
    n_err     = m_err;
    n_zero    = m_zero;
    was_full  = (m_stk.size() == SD);
    was_empty = (m_stk.size() == 0);
    case (wr_src)
      2'd0: wdata = alu_result;
      2'd1: wdata = immediate;
      2'd2: wdata = mem_rdata;
      default: wdata = m_regs[rx_index];
    endcase
    pop_ok  = pop && !push && !was_empty;
    push_ok = push && !pop && !was_full;
    if ((push && pop) || (push && was_full) || (pop && was_empty)) n_err = 1'b1;
    else if (err_clr) n_err = 1'b0;
    if (wr_en && !(pop_ok && wr_index == 0)) n_regs[wr_index] = wdata;
    if (wr_en) n_zero = (wdata == 0);
    if (pop_ok) begin
      pv        = n_stk.pop_back();
      n_regs[0] = pv;
      n_zero    = (pv == 0);
    end
    if (push_ok) n_stk.push_back(m_regs[0]);
  endtask

  // One clock: check outputs mid-cycle, then commit the model at the edge.
  task automatic cycle();
    predict();
    @(negedge clk);
`ifdef REG_FILE_BYPASS_EN
    check("r0", r0, n_regs[0]);
    check("rX", rX, n_regs[rx_index]);
`else
    check("r0", r0, m_regs[0]);
    check("rX", rX, m_regs[rx_index]);
`endif
    check("full",  stack_full,  32'(m_stk.size() == SD));
    check("empty", stack_empty, 32'(m_stk.size() == 0));
    check("err",   stack_err,   m_err);
    check("zero",  flag_zero,   m_zero);
    @(posedge clk);
    m_regs = n_regs;
    m_stk  = n_stk;
    m_err  = n_err;
    m_zero = n_zero;
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [DW-1:0] val);
    set_idle(); wr_en = 1; wr_index = idx; wr_src = 2'd1; immediate = val;
    cycle();
  endtask

  task automatic do_push();
    set_idle(); push = 1; cycle();
  endtask

  task automatic do_pop();
    set_idle(); pop = 1; cycle();
  endtask

  initial begin
    set_idle();
    rx_index = 0;
    rst_n    = 0;
    model_reset();
    #12;
    rst_n = 1;
    @(posedge clk); #1;

    // Reset in the middle of a write to reg3.
    wr(3'd1, 8'h77);
    set_idle(); wr_en = 1; wr_index = 3; wr_src = 2'd1; immediate = 8'h5A; rx_index = 3;
    #2 rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    set_idle();
    #1;
    check("rst_reg3", rX, 8'h00);
    check("rst_r0", r0, 8'h00);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_full", stack_full, 1'b0);
    check("rst_zero", flag_zero, 1'b1);
    check("rst_err", stack_err, 1'b0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    cycle();

    // Write reg5 and read it back through rX.
    set_idle(); wr_en = 1; wr_index = 5; wr_src = 2'd1; immediate = 8'h33; rx_index = 5;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("wr_cycle_rX", rX, 8'h33);
`else
    check("wr_cycle_rX", rX, 8'h00);
`endif
    cycle();
    set_idle(); #1;
    check("rd_rX", rX, 8'h33);
    check("wr_zero", flag_zero, 1'b0);
    cycle();

    // Fill the stack, overflow it, then drain it.
    for (int v = 8'h11; v <= 8'h14; v++) begin
      wr(3'd0, 8'(v));
      do_push();
    end
    check("full4", stack_full, 1'b1);
    do_push();
    check("ovf_err", stack_err, 1'b1);
    check("ovf_full", stack_full, 1'b1);
    set_idle(); err_clr = 1; cycle();
    for (int k = 0; k < 4; k++) begin
      do_pop();
      check("pop_r0", r0, 32'(8'h14 - k));
    end
    check("drained", stack_empty, 1'b1);

    // Underflow, then clear the error.
    do_pop();
    check("udf_err", stack_err, 1'b1);
    check("udf_r0", r0, 8'h11);
    set_idle(); err_clr = 1; cycle();
    check("clr_err", stack_err, 1'b0);

    // Pop versus simultaneous write.
    wr(3'd0, 8'hAA);
    do_push();
    set_idle(); pop = 1; wr_en = 1; wr_index = 0; wr_src = 2'd1; immediate = 8'h55;
    cycle();
    check("pop_wins", r0, 8'hAA);
    do_push();
    set_idle(); pop = 1; wr_en = 1; wr_index = 2; wr_src = 2'd1; immediate = 8'h55;
    rx_index = 2;
    cycle();
    set_idle(); #1;
    check("pop_r0_other", r0, 8'hAA);
    check("pop_wr2", rX, 8'h55);

    // Push and pop together.
    do_push();
    do_push();
    set_idle(); push = 1; pop = 1; cycle();
    check("coll_err", stack_err, 1'b1);
    check("coll_r0", r0, 8'hAA);
    set_idle(); wr_en = 1; wr_index = 1; wr_src = 2'd0; alu_result = 8'h00; cycle();
    check("zero_set", flag_zero, 1'b1);
    do_pop();
    do_pop();
    check("coll_cnt", stack_empty, 1'b1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      set_idle();
      wr_en      = ($urandom_range(0, 2) != 0);
      wr_index   = 3'($urandom);
      wr_src     = 2'($urandom);
      rx_index   = 3'($urandom);
      alu_result = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      immediate  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      mem_rdata  = 8'($urandom);
      push       = ($urandom_range(0, 3) == 0);
      pop        = ($urandom_range(0, 3) == 0);
      err_clr    = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
